clock_control_multi: RTL and testbench
======================================

// Module: clock_control_multi
// PURPOSE
//  Multi-link successor to the single-link clock-control demo. Aggregates N elastic-buffer
//  occupancies, drives FINC/FDEC frequency-step pulses, and runs per-link EB mode FSMs.
//  Also keeps per-link sticky error flags and stability detectors.
//  Sits in the controllable (external) clock domain between the link EBs and the clock synthesiser.
// PARAMETERS
//  NUM_LINKS      4     number of elastic-buffer links (1..16)
//  COUNT_WIDTH    8     EB occupancy width; midpoint MID = 2**(COUNT_WIDTH-1)
//  STABLE_MARGIN  16    max |ebCount-MID| counted as stable
//  STABLE_CYCLES  1024  consecutive in-margin cycles required for isStable
//  PULSE_WIDTH    4     cycles FINC/FDEC held high per step (>=1)
//  PULSE_SPACING  64    idle cycles enforced after each pulse (>=1)
// PORTS
//  clkExternal          in   1                      sole clock, rising edge
//  rstExternal          in   1                      synchronous, active-high reset
//  linkMask             in   NUM_LINKS              1 = link enabled
//  ebCount              in   NUM_LINKS*COUNT_WIDTH  per-link unsigned occupancy, link i at [i*W +: W]
//  ebUnderflow          in   NUM_LINKS              1-cycle underflow pulse from EB i
//  ebOverflow           in   NUM_LINKS              1-cycle overflow pulse from EB i
//  drainFifo            in   1                      level; forces all enabled links to DRAIN
//  stabilityCheckReset  in   1                      level; clears all stability counters
//  FINC                 out  1                      frequency-increment pulse
//  FDEC                 out  1                      frequency-decrement pulse
//  Underflowed          out  NUM_LINKS              sticky underflow flag per link
//  Overflowed           out  NUM_LINKS              sticky overflow flag per link
//  isStable             out  NUM_LINKS              link i stable for STABLE_CYCLES
//  allStable            out  1                      all enabled links stable
//  EbMode               out  2*NUM_LINKS            per link: 00 PASS, 01 FILL, 10 DRAIN
// BEHAVIOUR
//  - All outputs registered. On the rstExternal edge, FINC=FDEC=0, flags=0, and isStable=allStable=0.
//    Also on reset: every EbMode=01 (FILL), pulse FSM=IDLE, all counters=0.
//  - Error term: err = sum over enabled links in PASS of (ebCount_i - MID).
//    err is signed, width COUNT_WIDTH+clog2(NUM_LINKS)+1, so it cannot overflow. It is registered (1 cycle).
//  - Pulse FSM has three states: IDLE, PULSE, HOLD.
//    IDLE: if any enabled link is not in PASS, or linkMask==0, stay in IDLE.
//    IDLE: else if err>0, go to PULSE with FINC; if err<0, go to PULSE with FDEC; err==0 stays in IDLE.
//    PULSE: hold the chosen output high for exactly PULSE_WIDTH cycles, then go to HOLD. The direction is latched at entry.
//    HOLD: both outputs low for PULSE_SPACING cycles, then go to IDLE.
//    FINC and FDEC are never high together. Latency from ebCount to FINC rising is 2 cycles.
//  - EbMode FSM, one per link; evaluate in this priority order:
//    1) link disabled: FILL.
//    2) drainFifo or ebOverflow_i: DRAIN.
//    3) DRAIN and ebCount_i==0: FILL.
//    4) ebUnderflow_i in PASS: FILL.
//    5) FILL and ebCount_i>=MID: PASS.
//    Otherwise hold state. When overflow and underflow arrive in the same cycle, DRAIN wins.
//  - Sticky flags: Underflowed_i / Overflowed_i set on the matching pulse while link i is enabled.
//    They are cleared only by rstExternal. Both may set in the same cycle.
//  - Stability counter per link:
//    stabilityCheckReset has top priority and clears the counter to 0.
//    Else, if link enabled, in PASS and |ebCount_i-MID|<=STABLE_MARGIN: increment, saturating at STABLE_CYCLES.
//    Else: clear to 0.
//    isStable_i = (counter==STABLE_CYCLES).
//    allStable = (linkMask!=0) AND isStable_i for every enabled link.
//  - Reset mid-pulse drops FINC/FDEC at that edge; no partial pulse resumes afterwards.
//  - Clearing a linkMask bit mid-operation excludes that link from err on the next registered sample.
// TESTING
//  1 Reset: assert rstExternal 3 cycles -> FINC=FDEC=0, EbMode=0x55 (N=4), all flags and stable outputs 0.
//  2 Fill to PASS: all ebCount=128 -> EbMode=00 for all links.
//    Then set link0=140 -> FINC high 4 cycles, low >=64 cycles, repeating; FDEC stays 0.
//  3 Sum cancellation: PASS, ebCount={120,136,128,128} -> err=0, no pulses.
//    Set link2=100 -> FDEC pulses begin 2 cycles later.
//  4 Errors: ebOverflow[1] pulse -> Overflowed=0010 and link1 DRAIN; ebCount1=0 -> FILL.
//    Pulses stay suppressed until link1 returns to PASS. Overflowed stays set.
//  5 Stability: hold ebCount=130 for 1024 cycles -> isStable=1111, allStable=1.
//    Pulse stabilityCheckReset -> isStable=0 next cycle, recovers after 1024 cycles.
//  6 Masking and drain: linkMask=0011, drive link3 with ebOverflow -> no flag set.
//    Assert drainFifo -> links 0,1 DRAIN, links 2,3 FILL. Reset during FINC -> FINC=0 on that edge.

Source files
------------

// File: rtl/clock_control_multi.sv
// clock_control_multi: aggregates N elastic-buffer occupancies into a signed error term,
// steps the clock synthesiser with FINC/FDEC pulses, and runs per-link EB mode FSMs,
// sticky error flags and stability detectors.
//
// Pulse FSM states
//   state   | meaning
//   P_IDLE  | waiting for all enabled links in PASS and a non-zero error
//   P_PULSE | FINC or FDEC held high for PULSE_WIDTH cycles, direction latched at entry
//   P_HOLD  | both outputs low for PULSE_SPACING cycles before re-arming
//
// EbMode states (per link)
//   mode       | meaning
//   MODE_PASS  | 00 buffer centred, contributes to the error term
//   MODE_FILL  | 01 buffer refilling until occupancy reaches the midpoint
//   MODE_DRAIN | 10 buffer emptying until occupancy reaches zero
module clock_control_multi #(
  parameter int NUM_LINKS     = 4,
  parameter int COUNT_WIDTH   = 8,
  parameter int STABLE_MARGIN = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int PULSE_WIDTH   = 4,
  parameter int PULSE_SPACING = 64
) (
  input  logic                             clkExternal,
  input  logic                             rstExternal,
  input  logic [NUM_LINKS-1:0]             linkMask,
  input  logic [NUM_LINKS*COUNT_WIDTH-1:0] ebCount,
  input  logic [NUM_LINKS-1:0]             ebUnderflow,
  input  logic [NUM_LINKS-1:0]             ebOverflow,
  input  logic                             drainFifo,
  input  logic                             stabilityCheckReset,
  output logic                             FINC,
  output logic                             FDEC,
  output logic [NUM_LINKS-1:0]             Underflowed,
  output logic [NUM_LINKS-1:0]             Overflowed,
  output logic [NUM_LINKS-1:0]             isStable,
  output logic                             allStable,
  output logic [2*NUM_LINKS-1:0]           EbMode
);

  localparam int ERR_W  = COUNT_WIDTH + $clog2(NUM_LINKS) + 1;
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int PMAX   = (PULSE_WIDTH > PULSE_SPACING) ? PULSE_WIDTH : PULSE_SPACING;
  localparam int PCNT_W = $clog2(PMAX) + 1;

  localparam logic [COUNT_WIDTH-1:0]  MID_C    = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic [COUNT_WIDTH-1:0]  MARGIN_C = COUNT_WIDTH'(STABLE_MARGIN);
  localparam logic signed [ERR_W-1:0] MID_E    = $signed({{(ERR_W-COUNT_WIDTH){1'b0}}, MID_C});
  localparam logic [STAB_W-1:0]       STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [PCNT_W-1:0]       PW_LOAD  = PCNT_W'(PULSE_WIDTH - 1);
  localparam logic [PCNT_W-1:0]       PS_LOAD  = PCNT_W'(PULSE_SPACING - 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_FILL  = 2'b01,
    MODE_DRAIN = 2'b10
  } eb_mode_e;

  typedef enum logic [1:0] {
    P_IDLE  = 2'b00,
    P_PULSE = 2'b01,
    P_HOLD  = 2'b10
  } pulse_state_e;

  logic [COUNT_WIDTH-1:0]  link_cnt [NUM_LINKS];
  logic [COUNT_WIDTH-1:0]  abs_diff [NUM_LINKS];
  logic [NUM_LINKS-1:0]    in_margin;

  eb_mode_e                mode_q [NUM_LINKS];
  eb_mode_e                mode_d [NUM_LINKS];

  logic signed [ERR_W-1:0] err_q, err_d;
  logic                    blocked;

  pulse_state_e            state_q, state_d;
  logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
  logic                    dir_inc_q, dir_inc_d;
  logic                    finc_q, finc_d;
  logic                    fdec_q, fdec_d;

  logic [NUM_LINKS-1:0]    und_q, und_d;
  logic [NUM_LINKS-1:0]    ovf_q, ovf_d;
  logic [STAB_W-1:0]       stab_q [NUM_LINKS];
  logic [STAB_W-1:0]       stab_d [NUM_LINKS];
  logic [NUM_LINKS-1:0]    stable_q, stable_d;
  logic                    all_q, all_d;

  // Unpack per-link occupancy and measure its distance from the midpoint
  always_comb begin
    for (int i = 0; i < NUM_LINKS; i++) begin
      link_cnt[i] = ebCount[i*COUNT_WIDTH +: COUNT_WIDTH];
      if (link_cnt[i] >= MID_C) begin
        abs_diff[i] = link_cnt[i] - MID_C;
      end else begin
        abs_diff[i] = MID_C - link_cnt[i];
      end
      in_margin[i] = (abs_diff[i] <= MARGIN_C);
    end
  end

  // Signed error sum over enabled links currently in PASS
  always_comb begin
    err_d = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (linkMask[i] && (mode_q[i] == MODE_PASS)) begin
        err_d = err_d + $signed({{(ERR_W-COUNT_WIDTH){1'b0}}, link_cnt[i]}) - MID_E;
      end
    end
  end

  // Steering is suppressed while any enabled link is re-centring or nothing is enabled
  always_comb begin
    blocked = (linkMask == '0);
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (linkMask[i] && (mode_q[i] != MODE_PASS)) begin
        blocked = 1'b1;
      end
    end
  end

  // Pulse FSM next-state: direction latched on entry, down-counter times PULSE and HOLD
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    dir_inc_d = dir_inc_q;
    case (state_q)
      P_IDLE: begin
        if (!blocked && (err_q != '0)) begin
          state_d   = P_PULSE;
          dir_inc_d = ~err_q[ERR_W-1];
          pcnt_d    = PW_LOAD;
        end
      end
      P_PULSE: begin
        if (pcnt_q == '0) begin
          state_d = P_HOLD;
          pcnt_d  = PS_LOAD;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      P_HOLD: begin
        if (pcnt_q == '0) begin
          state_d = P_IDLE;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = P_IDLE;
        pcnt_d  = '0;
      end
    endcase
    finc_d = (state_d == P_PULSE) && dir_inc_d;
    fdec_d = (state_d == P_PULSE) && !dir_inc_d;
  end

  // Per-link EB mode next-state in priority order; overflow beats underflow
  always_comb begin
    for (int i = 0; i < NUM_LINKS; i++) begin
      mode_d[i] = mode_q[i];
      if (!linkMask[i]) begin
        mode_d[i] = MODE_FILL;
      end else if (drainFifo || ebOverflow[i]) begin
        mode_d[i] = MODE_DRAIN;
      end else if ((mode_q[i] == MODE_DRAIN) && (link_cnt[i] == '0)) begin
        mode_d[i] = MODE_FILL;
      end else if (ebUnderflow[i] && (mode_q[i] == MODE_PASS)) begin
        mode_d[i] = MODE_FILL;
      end else if ((mode_q[i] == MODE_FILL) && (link_cnt[i] >= MID_C)) begin
        mode_d[i] = MODE_PASS;
      end
    end
  end

  // Sticky error flags and saturating stability counters
  always_comb begin
    und_d    = und_q | (ebUnderflow & linkMask);
    ovf_d    = ovf_q | (ebOverflow & linkMask);
    stable_d = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (stabilityCheckReset) begin
        stab_d[i] = '0;
      end else if (linkMask[i] && (mode_q[i] == MODE_PASS) && in_margin[i]) begin
        stab_d[i] = (stab_q[i] == STAB_MAX) ? stab_q[i] : stab_q[i] + 1'b1;
      end else begin
        stab_d[i] = '0;
      end
      stable_d[i] = (stab_d[i] == STAB_MAX);
    end
    all_d = (linkMask != '0) && ((stable_d | ~linkMask) == '1);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clkExternal) begin
    if (rstExternal) begin
      err_q     <= '0;
      state_q   <= P_IDLE;
      pcnt_q    <= '0;
      dir_inc_q <= 1'b0;
      finc_q    <= 1'b0;
      fdec_q    <= 1'b0;
      und_q     <= '0;
      ovf_q     <= '0;
      stable_q  <= '0;
      all_q     <= 1'b0;
      for (int i = 0; i < NUM_LINKS; i++) begin
        mode_q[i] <= MODE_FILL;
        stab_q[i] <= '0;
      end
    end else begin
      err_q     <= err_d;
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      dir_inc_q <= dir_inc_d;
      finc_q    <= finc_d;
      fdec_q    <= fdec_d;
      und_q     <= und_d;
      ovf_q     <= ovf_d;
      stable_q  <= stable_d;
      all_q     <= all_d;
      for (int i = 0; i < NUM_LINKS; i++) begin
        mode_q[i] <= mode_d[i];
        stab_q[i] <= stab_d[i];
      end
    end
  end

  // Pack per-link modes onto the output bus
  always_comb begin
    EbMode = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      EbMode[2*i +: 2] = mode_q[i];
    end
  end

  assign FINC        = finc_q;
  assign FDEC        = fdec_q;
  assign Underflowed = und_q;
  assign Overflowed  = ovf_q;
  assign isStable    = stable_q;
  assign allStable   = all_q;

endmodule

// File: tb/tb_clock_control_multi.sv
// tb_clock_control_multi: directed and randomised stimulus, expected outputs from a
// cycle-indexed reference model pushed into a queue and checked by a separate monitor.
module tb_clock_control_multi;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int MID    = 128;
  localparam int MARGIN = 16;
  localparam int SC     = 1024;
  localparam int PW     = 4;
  localparam int PS     = 64;
  localparam int PASS   = 0;
  localparam int FILL   = 1;
  localparam int DRAIN  = 2;

  logic             clkExternal = 1'b0;
  logic             rstExternal;
  logic [N-1:0]     linkMask;
  logic [N*W-1:0]   ebCount;
  logic [N-1:0]     ebUnderflow;
  logic [N-1:0]     ebOverflow;
  logic             drainFifo;
  logic             stabilityCheckReset;
  logic             FINC, FDEC;
  logic [N-1:0]     Underflowed, Overflowed, isStable;
  logic             allStable;
  logic [2*N-1:0]   EbMode;

  clock_control_multi #(
    .NUM_LINKS(N), .COUNT_WIDTH(W), .STABLE_MARGIN(MARGIN),
    .STABLE_CYCLES(SC), .PULSE_WIDTH(PW), .PULSE_SPACING(PS)
  ) dut (
    .clkExternal(clkExternal), .rstExternal(rstExternal), .linkMask(linkMask),
    .ebCount(ebCount), .ebUnderflow(ebUnderflow), .ebOverflow(ebOverflow),
    .drainFifo(drainFifo), .stabilityCheckReset(stabilityCheckReset),
    .FINC(FINC), .FDEC(FDEC), .Underflowed(Underflowed), .Overflowed(Overflowed),
    .isStable(isStable), .allStable(allStable), .EbMode(EbMode)
  );

  always #5 clkExternal = ~clkExternal;

  typedef struct {
    logic         finc;
    logic         fdec;
    logic [N-1:0] und;
    logic [N-1:0] ovf;
    logic [N-1:0] stab;
    logic         all;
    logic [2*N-1:0] mode;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // stimulus values applied at the next falling edge
  logic         rst_v, drain_v, scr_v;
  logic [N-1:0] mask_v, unf_v, ovf_v;
  logic [W-1:0] cnt_v [N];

  // reference model state (values after the most recent rising edge)
  int           m_mode [N];
  int           m_stab [N];
  logic [N-1:0] m_und, m_ovf, m_stable;
  logic         m_all, m_finc, m_fdec;
  int           m_err;
  int           cyc_n;
  int           ps_start;
  bit           ps_dir;

  task automatic model_step();
    int  old_mode [N];
    int  e, d;
    bit  blk;
    if (rst_v) begin
      for (int i = 0; i < N; i++) begin
        m_mode[i] = FILL;
        m_stab[i] = 0;
      end
      m_und = '0; m_ovf = '0; m_stable = '0; m_all = 1'b0;
      m_finc = 1'b0; m_fdec = 1'b0; m_err = 0;
      ps_start = -100000;
    end else begin
      for (int i = 0; i < N; i++) old_mode[i] = m_mode[i];
      // a pulse started at edge s is high after edges s..s+PW-1, quiet until s+PW+PS
      if (cyc_n >= ps_start + PW + PS + 1) begin
        blk = (mask_v == '0);
        for (int i = 0; i < N; i++) if (mask_v[i] && old_mode[i] != PASS) blk = 1'b1;
        if (!blk && m_err != 0) begin
          ps_start = cyc_n;
          ps_dir   = (m_err > 0);
        end
      end
      m_finc = ((cyc_n - ps_start) < PW) && ps_dir;
      m_fdec = ((cyc_n - ps_start) < PW) && !ps_dir;
      e = 0;
      for (int i = 0; i < N; i++)
        if (mask_v[i] && old_mode[i] == PASS) e += int'(cnt_v[i]) - MID;
      m_err = e;
      m_und = m_und | (unf_v & mask_v);
      m_ovf = m_ovf | (ovf_v & mask_v);
      for (int i = 0; i < N; i++) begin
        if (!mask_v[i])                                   m_mode[i] = FILL;
        else if (drain_v || ovf_v[i])                     m_mode[i] = DRAIN;
        else if (old_mode[i] == DRAIN && cnt_v[i] == 0)   m_mode[i] = FILL;
        else if (unf_v[i] && old_mode[i] == PASS)         m_mode[i] = FILL;
        else if (old_mode[i] == FILL && cnt_v[i] >= MID)  m_mode[i] = PASS;
        d = int'(cnt_v[i]) - MID;
        if (d < 0) d = -d;
        if (scr_v) m_stab[i] = 0;
        else if (mask_v[i] && old_mode[i] == PASS && d <= MARGIN)
          m_stab[i] = (m_stab[i] >= SC) ? SC : m_stab[i] + 1;
        else m_stab[i] = 0;
        m_stable[i] = (m_stab[i] == SC);
      end
      m_all = (mask_v != '0);
      for (int i = 0; i < N; i++) if (mask_v[i] && !m_stable[i]) m_all = 1'b0;
    end
    cyc_n++;
  endtask

  task automatic cyc();
    exp_t x;
    @(negedge clkExternal);
    rstExternal         = rst_v;
    linkMask            = mask_v;
    ebUnderflow         = unf_v;
    ebOverflow          = ovf_v;
    drainFifo           = drain_v;
    stabilityCheckReset = scr_v;
    for (int i = 0; i < N; i++) ebCount[i*W +: W] = cnt_v[i];
    model_step();
    x.finc = m_finc; x.fdec = m_fdec; x.und = m_und; x.ovf = m_ovf;
    x.stab = m_stable; x.all = m_all;
    x.mode = '0;
    for (int i = 0; i < N; i++) x.mode[2*i +: 2] = 2'(m_mode[i]);
    exp_q.push_back(x);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic pulse_cycle();
    cyc();
    unf_v = '0; ovf_v = '0; scr_v = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) cnt_v[i] = W'(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // monitor: compares DUT outputs one step after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clkExternal);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("FINC",        int'(FINC),        int'(e.finc));
        chk("FDEC",        int'(FDEC),        int'(e.fdec));
        chk("Underflowed", int'(Underflowed), int'(e.und));
        chk("Overflowed",  int'(Overflowed),  int'(e.ovf));
        chk("isStable",    int'(isStable),    int'(e.stab));
        chk("allStable",   int'(allStable),   int'(e.all));
        chk("EbMode",      int'(EbMode),      int'(e.mode));
      end
    end
  end

  initial begin
    int r;
    cyc_n = 0; ps_start = -100000; ps_dir = 1'b0;
    rst_v = 1'b1; mask_v = '1; unf_v = '0; ovf_v = '0; drain_v = 1'b0; scr_v = 1'b0;
    set_all(0);

    // reset for three cycles
    run(3);
    rst_v = 1'b0;

    // fill to PASS, then positive error on link0
    set_all(128);
    run(5);
    cnt_v[0] = 8'd140;
    run(300);

    // cancelling errors, then net negative
    cnt_v[0] = 8'd120; cnt_v[1] = 8'd136; cnt_v[2] = 8'd128; cnt_v[3] = 8'd128;
    run(80);
    cnt_v[2] = 8'd100;
    run(200);

    // overflow on link1 forces DRAIN, empty returns it to FILL, refill restores PASS
    ovf_v[1] = 1'b1;
    pulse_cycle();
    run(3);
    cnt_v[1] = 8'd0;
    run(100);
    cnt_v[1] = 8'd128;
    run(200);

    // stability build-up, clear, and recovery
    set_all(130);
    run(1100);
    scr_v = 1'b1;
    pulse_cycle();
    run(1100);

    // masking and drain
    mask_v = 4'b0011;
    run(3);
    ovf_v[3] = 1'b1;
    pulse_cycle();
    drain_v = 1'b1;
    run(3);
    drain_v = 1'b0;
    cnt_v[0] = 8'd0; cnt_v[1] = 8'd0;
    run(3);
    cnt_v[0] = 8'd140; cnt_v[1] = 8'd128;
    begin
      int k;
      k = 0;
      while (!m_finc && k < 300) begin
        cyc();
        k++;
      end
      checks++;
      if (!m_finc) begin
        errors++;
        $display("FAIL finc_reached: got 0 expected 1 within 300 cycles");
      end
    end
    rst_v = 1'b1;
    cyc();
    rst_v = 1'b0;
    mask_v = '1;
    set_all(128);
    run(20);

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 3) begin
          r = $urandom_range(0, 99);
          if (r < 4)      cnt_v[i] = 8'd0;
          else if (r < 6) cnt_v[i] = 8'd255;
          else            cnt_v[i] = W'(108 + $urandom_range(0, 40));
        end
        unf_v[i] = ($urandom_range(0, 99) < 2);
        ovf_v[i] = ($urandom_range(0, 99) < 1);
      end
      drain_v = ($urandom_range(0, 99) < 2);
      scr_v   = ($urandom_range(0, 99) < 2);
      rst_v   = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 99) < 2) mask_v = N'($urandom_range(0, 15));
      cyc();
    end
    rst_v = 1'b0; unf_v = '0; ovf_v = '0; drain_v = 1'b0; scr_v = 1'b0;
    run(5);

    repeat (3) @(posedge clkExternal);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
